// File: rtl/fan_speed.sv
// Fixed-frequency PWM fan-speed generator: period 2**WIDTH clocks, duty speed/2**WIDTH.
// Optional soft start: define FAN_SPEED_RAMP_EN to limit the per-period change to RAMP_STEP.
module fan_speed #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] speed,
  output logic             pwm_data
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] speed_q;
  logic [WIDTH-1:0] speed_q_next;
  logic [WIDTH-1:0] speed_target;
  logic             wrap;

  always_comb begin
    cnt_next = cnt + WIDTH'(1);
    wrap     = (cnt == '1);
  end

`ifdef FAN_SPEED_RAMP_EN
  // One extra bit keeps the +/- step comparisons from wrapping.
  logic [WIDTH:0] speed_ext;
  logic [WIDTH:0] applied_ext;
  logic [WIDTH:0] step_ext;

  always_comb begin
    speed_ext    = {1'b0, speed};
    applied_ext  = {1'b0, speed_q};
    step_ext     = (WIDTH+1)'(RAMP_STEP);
    speed_target = speed;
    if (speed_ext > applied_ext + step_ext)
      speed_target = WIDTH'(applied_ext + step_ext);
    else if (speed_ext + step_ext < applied_ext)
      speed_target = WIDTH'(applied_ext - step_ext);
  end
`else
  logic unused_ramp_step;

  always_comb begin
    speed_target     = speed;
    unused_ramp_step = |RAMP_STEP;
  end
`endif

  always_comb begin
    speed_q_next = wrap ? speed_target : speed_q;
  end

  // Output is compared against next-state values so it lines up with cnt.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt      <= '0;
      speed_q  <= '0;
      pwm_data <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      speed_q  <= speed_q_next;
      pwm_data <= (cnt_next < speed_q_next);
    end
  end

endmodule

// File: tb/tb_fan_speed.sv
// Scoreboard bench for fan_speed: reference model predicts pwm_data per cycle from the
// period/duty rules; an independent monitor pops and compares, and checks rise spacing.
module tb_fan_speed;

  localparam int WIDTH     = 8;
  localparam int RAMP_STEP = 1;
  localparam int P         = 1 << WIDTH;

  logic             clk;
  logic             arst;
  logic [WIDTH-1:0] speed;
  logic             pwm_data;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];
  bit rise_chk = 1'b0;

  // reference model state: edges since reset release, and duty applied this period
  int k       = 0;
  int applied = 0;

  fan_speed #(.WIDTH(WIDTH), .RAMP_STEP(RAMP_STEP)) dut (
    .clk      (clk),
    .arst     (arst),
    .speed    (speed),
    .pwm_data (pwm_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic int next_applied(input int s, input int a);
`ifdef FAN_SPEED_RAMP_EN
    int d;
    d = s - a;
    if (d > RAMP_STEP) return a + RAMP_STEP;
    if (d < -RAMP_STEP) return a - RAMP_STEP;
    return s;
`else
    return s + 0 * a;
`endif
  endfunction

  // Called at a falling edge: drive speed for the next rising edge and predict its result.
  task automatic edge_step(input int s);
    speed = WIDTH'(s);
    if (arst) begin
      exp_q.push_back(1'b0);
    end else begin
      k++;
      if (k % P == 0) applied = next_applied(s, applied);
      exp_q.push_back((k % P) < applied);
    end
    @(negedge clk);
  endtask

  task automatic run(input int s, input int n);
    for (int i = 0; i < n; i++) edge_step(s);
  endtask

  task automatic run_to_pos(input int s, input int pos);
    while (k % P != pos) edge_step(s);
  endtask

  task automatic async_reset(input int hold);
    arst = 1'b1;
    #1;
    checks++;
    if (pwm_data !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pwm_data=%b required 0", pwm_data);
    end
    k       = 0;
    applied = 0;
    @(negedge clk);
    run(0, hold);
    arst = 1'b0;
  endtask

  // monitor
  initial begin
    bit e;
    bit prev;
    int cyc;
    int last_rise;
    prev      = 1'b0;
    cyc       = 0;
    last_rise = -1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pwm_data !== e) begin
          errors++;
          $display("FAIL pwm cyc=%0d: got %b required %b", cyc, pwm_data, e);
        end
      end
      if (!rise_chk) begin
        last_rise = -1;
      end else if (pwm_data && !prev) begin
        if (last_rise >= 0) begin
          checks++;
          if (cyc - last_rise != P) begin
            errors++;
            $display("FAIL rise_period cyc=%0d: got %0d required %0d", cyc, cyc - last_rise, P);
          end
        end
        last_rise = cyc;
      end
      prev = pwm_data;
    end
  end

  // stimulus
  initial begin
    int s;
    arst  = 1'b1;
    speed = '0;
    @(negedge clk);
    run(4, 3);
    arst = 1'b0;

    run(4, 3 * P);
    run(0, 3 * P);
    run(255, 3 * P);

    run_to_pos(4, 0);
    run(4, P);
    run_to_pos(4, 50);
    run(128, 2 * P + 10);

    run_to_pos(200, 0);
    run(200, 2 * P);
    run_to_pos(200, 2);
    async_reset(2);
    run(200, 2 * P);

    // ramp-up then ramp-down pattern
    async_reset(1);
    run(3, 5 * P);
    run(0, 4 * P);

    s = 0;
    for (int i = 0; i < 20 * P; i++) begin
      if ((k % P == P - 1 && $urandom_range(3) == 0) || $urandom_range(63) == 0) begin
        case ($urandom_range(5))
          0:       s = 0;
          1:       s = P - 1;
          default: s = int'($urandom_range(P - 1));
        endcase
      end
      edge_step(s);
    end

    s = int'($urandom_range(P - 1, 1));
    run(s, 2 * P);
    rise_chk = 1'b1;
    for (int i = 0; i < 10 * P; i++) begin
      if ($urandom_range(127) == 0) s = int'($urandom_range(P - 1, 1));
      edge_step(s);
    end
    rise_chk = 1'b0;

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
